// File: rtl/sbox_stream_pkg.sv
// Shared AES byte-substitution definitions: lane width, legal lane range and mode encoding.
package sbox_stream_pkg;

  localparam int LANE_W    = 8;
  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 16;

  typedef enum logic {
    SBOX_FWD = 1'b0,
    SBOX_INV = 1'b1
  } sbox_mode_e;

  function automatic bit lanes_legal(input int lanes);
    return (lanes >= LANES_MIN) && (lanes <= LANES_MAX);
  endfunction

endpackage

// File: rtl/sbox_lut_dual.sv
// Single-byte combinational lookup holding both the FIPS-197 S-box and its inverse.
module sbox_lut_dual
  import sbox_stream_pkg::*;
(
  input  logic [LANE_W-1:0] din,
  input  logic              inv,
  output logic [LANE_W-1:0] dout
);

  // Entry 0x00 sits in the top byte, so the slice base is (255 - din) * 8.
  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  always_comb begin
    if (sbox_mode_e'(inv) == SBOX_INV)
      dout = INV_TABLE[{~din, 3'b000} +: LANE_W];
    else
      dout = FWD_TABLE[{~din, 3'b000} +: LANE_W];
  end

endmodule

// File: rtl/sbox_stream.sv
// Two-stage elastic byte-substitution pipeline: LANES bytes per beat, per-beat mode, per-lane mask.
module sbox_stream
  import sbox_stream_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANE_W*LANES-1:0]  in_data,
  input  logic                     in_inv,
  input  logic [LANES-1:0]         in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANE_W*LANES-1:0]  out_data,
  output logic                     out_inv,
  output logic [15:0]              beat_cnt
);

  localparam bit LANES_OK = lanes_legal(LANES);

  if (!LANES_OK) begin : g_lanes_check
    $error("sbox_stream: LANES must be within 1..16");
  end

  logic                    s1_valid;
  logic [LANE_W*LANES-1:0] s1_data;
  logic                    s1_inv;
  logic [LANES-1:0]        s1_mask;
  logic                    s2_valid;
  logic [LANE_W*LANES-1:0] s2_data;
  logic                    s2_inv;
  logic [LANE_W*LANES-1:0] sub_data;
  logic                    s1_load;
  logic                    s2_load;

  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign s1_load  = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lut_out;

    sbox_lut_dual u_lut (
      .din  (s1_data[i*LANE_W +: LANE_W]),
      .inv  (s1_inv),
      .dout (lut_out)
    );

    assign sub_data[i*LANE_W +: LANE_W] = s1_mask[i] ? lut_out : s1_data[i*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_inv   <= 1'b0;
      s1_mask  <= '0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_inv   <= in_inv;
      s1_mask  <= in_mask;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register only changes on a load, so stalled data holds by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_inv   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_data  <= sub_data;
      s2_inv   <= s1_inv;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      beat_cnt <= '0;
    else if (out_valid && out_ready)
      beat_cnt <= beat_cnt + 16'd1;
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_inv   = s2_inv;

endmodule

// File: tb/tb_sbox_stream.sv
// Scoreboard bench for sbox_stream: a 4-lane and a 16-lane instance checked against an algorithmic AES S-box model.
module tb_sbox_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         v4 = 1'b0, inv4 = 1'b0, ordy4 = 1'b1;
  logic [31:0]  d4 = '0;
  logic [3:0]   m4 = '0;
  logic         rdy4, ov4, oi4;
  logic [31:0]  od4;
  logic [15:0]  cnt4;

  logic         v16 = 1'b0, inv16 = 1'b0, ordy16 = 1'b1;
  logic [127:0] d16 = '0;
  logic [15:0]  m16 = '0;
  logic         rdy16, ov16, oi16;
  logic [127:0] od16;
  logic [15:0]  cnt16;

  int           vectors = 0;
  int           miscompares = 0;
  logic [128:0] q4[$];
  logic [128:0] q16[$];
  logic [128:0] exp4, exp16, held4, held16;
  logic         hold4 = 1'b0, hold16 = 1'b0;
  logic [15:0]  exp_cnt4 = '0, exp_cnt16 = '0;
  logic [7:0]   fwd_tab[256];
  logic [7:0]   inv_tab[256];

  sbox_stream #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_inv(inv4),
    .in_mask(m4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_inv(oi4),
    .beat_cnt(cnt4)
  );

  sbox_stream #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .in_data(d16), .in_inv(inv16),
    .in_mask(m16), .out_valid(ov16), .out_ready(ordy16), .out_data(od16), .out_inv(oi16),
    .beat_cnt(cnt16)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv, input logic [15:0] m);
    logic [127:0] r;
    r = d;
    for (int i = 0; i < 16; i++)
      if (m[i]) r[i*8 +: 8] = inv ? inv_tab[d[i*8 +: 8]] : fwd_tab[d[i*8 +: 8]];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic i, input logic [3:0] m);
    int n = 0;
    v4 = 1'b1; d4 = d; inv4 = i; m4 = m;
    @(negedge clk);
    while (!rdy4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("accept4", rdy4, 1);
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  task automatic applyStimulus16(input logic [127:0] d, input logic i);
    int n = 0;
    v16 = 1'b1; d16 = d; inv16 = i; m16 = 16'hFFFF;
    @(negedge clk);
    while (!rdy16 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("accept16", rdy16, 1);
    @(posedge clk); #1;
    v16 = 1'b0;
  endtask

  // 4-lane scoreboard: readiness, stall hold, beat count, ordered output.
  always @(negedge clk) begin
    if (rst) begin
      q4.delete();
      exp_cnt4 = '0;
      hold4 = 1'b0;
    end else begin
      checkOutput("in_ready4", rdy4, !(q4.size() == 2 && !ordy4));
      checkOutput("beat_cnt4", cnt4, exp_cnt4);
      if (hold4) begin
        checkOutput("stall_valid4", ov4, 1);
        checkOutput("stall_hold4", {oi4, 96'b0, od4}, held4);
      end
      hold4 = ov4 && !ordy4;
      held4 = {oi4, 96'b0, od4};
      if (ov4 && ordy4) begin
        checkOutput("sb_nonempty4", q4.size() != 0, 1);
        if (q4.size() != 0) begin
          exp4 = q4.pop_front();
          checkOutput("out4", {oi4, 96'b0, od4}, exp4);
          exp_cnt4 = exp_cnt4 + 16'd1;
        end
      end
      if (v4 && rdy4)
        q4.push_back({inv4, model({96'b0, d4}, inv4, {12'b0, m4})});
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      exp_cnt16 = '0;
      hold16 = 1'b0;
    end else begin
      checkOutput("in_ready16", rdy16, !(q16.size() == 2 && !ordy16));
      checkOutput("beat_cnt16", cnt16, exp_cnt16);
      if (hold16) checkOutput("stall_hold16", {oi16, od16}, held16);
      hold16 = ov16 && !ordy16;
      held16 = {oi16, od16};
      if (ov16 && ordy16) begin
        checkOutput("sb_nonempty16", q16.size() != 0, 1);
        if (q16.size() != 0) begin
          exp16 = q16.pop_front();
          checkOutput("out16", {oi16, od16}, exp16);
          exp_cnt16 = exp_cnt16 + 16'd1;
        end
      end
      if (v16 && rdy16)
        q16.push_back({inv16, model(d16, inv16, m16)});
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]   y;
    logic [7:0]   s;
    logic [127:0] wide;

    for (int x = 0; x < 256; x++) begin
      y = '0;
      if (x != 0)
        for (int c = 1; c < 256; c++)
          if (gmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", rdy4, 0);
    checkOutput("reset_out_valid", ov4, 0);
    checkOutput("reset_out_data", od4, 0);
    checkOutput("reset_out_inv", oi4, 0);
    checkOutput("reset_beat_cnt", cnt4, 0);
    checkOutput("reset_out_valid16", ov16, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_release", rdy4, 1);
    @(posedge clk); #1;

    // Directed single beats with exact two-edge latency.
    applyStimulus(32'h53FF0100, 1'b0, 4'hF);
    checkOutput("lat_edge1_fwd", ov4, 0);
    @(posedge clk); #1;
    checkOutput("lat_edge2_fwd", ov4, 1);
    checkOutput("fwd_data", od4, 32'hED167C63);
    checkOutput("fwd_mode", oi4, 0);
    @(posedge clk); #1;

    applyStimulus(32'hED167C63, 1'b1, 4'hF);
    @(posedge clk); #1;
    checkOutput("inv_data", od4, 32'h53FF0100);
    checkOutput("inv_mode", oi4, 1);
    @(posedge clk); #1;

    applyStimulus(32'h00000000, 1'b0, 4'b0101);
    @(posedge clk); #1;
    checkOutput("mask_data", od4, 32'h00630063);
    @(posedge clk); #1;

    // Alternating modes back to back.
    applyStimulus(32'h53FF0100, 1'b0, 4'hF);
    applyStimulus(32'hED167C63, 1'b1, 4'hF);
    applyStimulus(32'h53FF0100, 1'b0, 4'hF);
    applyStimulus(32'hED167C63, 1'b1, 4'hF);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 10 beats against an out_ready pattern of 1,0,0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fork
      begin
        for (int k = 0; k < 10; k++)
          applyStimulus($urandom, 1'(k % 2), 4'($urandom));
      end
      begin
        for (int cyc = 0; cyc < 300 && exp_cnt4 != 16'd10; cyc++) begin
          ordy4 = (cyc % 3 == 0);
          @(posedge clk); #1;
        end
        ordy4 = 1'b1;
      end
    join
    checkOutput("bp_beat_cnt", cnt4, 10);
    checkOutput("bp_sb_empty", q4.size(), 0);

    // Reset with two beats in flight.
    ordy4 = 1'b0;
    applyStimulus(32'h11223344, 1'b0, 4'hF);
    applyStimulus(32'h55667788, 1'b1, 4'hF);
    checkOutput("full_in_ready", rdy4, 0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", ov4, 0);
    checkOutput("midrst_beat_cnt", cnt4, 0);
    checkOutput("midrst_out_data", od4, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ordy4 = 1'b1;
    #1;
    checkOutput("postrst_in_ready", rdy4, 1);
    applyStimulus(32'h53FF0100, 1'b0, 4'hF);
    checkOutput("postrst_edge1", ov4, 0);
    @(posedge clk); #1;
    checkOutput("postrst_edge2", ov4, 1);
    checkOutput("postrst_data", od4, 32'hED167C63);
    @(posedge clk); #1;

    // 16 lanes: every byte forward, then the forward results inverted.
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 16; b++) wide[b*8 +: 8] = 8'(16 * k + b);
      applyStimulus16(wide, 1'b0);
    end
    for (int k = 0; k < 16; k++) begin
      for (int b = 0; b < 16; b++) wide[b*8 +: 8] = fwd_tab[16 * k + b];
      applyStimulus16(wide, 1'b1);
    end
    @(posedge clk); #1;
    checkOutput("roundtrip_last", od16, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
    checkOutput("roundtrip_mode", oi16, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wide_beat_cnt", cnt16, 32);
    checkOutput("wide_sb_empty", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
